mips_branch_predictor: RTL and testbench

MIPS_BRANCH_PREDICTOR -- requirements
Module: mips_branch_predictor

---
 rtl/mips_branch_predictor.sv | 149 ++++++++++++++
 tb/tb_mips_branch_predictor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_branch_predictor.sv
// Bimodal branch predictor: per-index saturating counters, one-cycle lookup.
// Define MIPS_BP_BTB_EN to add per-entry valid/tag/target (BTB) storage.
module mips_branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int PC_W    = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            lookup_valid,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic            pred_hit,
    output logic [PC_W-1:0] pred_target,
    input  logic            update_valid,
    input  logic [PC_W-1:0] update_pc,
    input  logic            update_taken,
    input  logic [PC_W-1:0] update_target,
    input  logic            update_pred_taken,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_MAX >> 1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_WNT + CTR_W'(1);

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic             lk_hit;
    logic             up_hit;
    logic             lk_msb;
    logic             unused;

    logic [CTR_W-1:0] ctr [ENTRIES];
    logic [CTR_W-1:0] ctr_up;
    logic [CTR_W-1:0] ctr_inc;
    logic [CTR_W-1:0] ctr_dec;
    logic [CTR_W-1:0] ctr_nx;

    assign lk_idx  = lookup_pc[IDX_W+1:2];
    assign up_idx  = update_pc[IDX_W+1:2];
    assign lk_msb  = ctr[lk_idx][CTR_W-1];
    assign ctr_up  = ctr[up_idx];
    assign ctr_inc = (ctr_up == CTR_MAX) ? ctr_up : ctr_up + CTR_W'(1);
    assign ctr_dec = (ctr_up == '0) ? ctr_up : ctr_up - CTR_W'(1);

    // A taken branch that misses the target buffer restarts at weakly-taken.
    always_comb begin
        ctr_nx = update_taken ? ctr_inc : ctr_dec;
        if (update_taken && !up_hit) begin
            ctr_nx = CTR_WT;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_WNT;
            end
        end else if (update_valid) begin
            ctr[up_idx] <= ctr_nx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            pred_valid <= lookup_valid;
            pred_taken <= lookup_valid && lk_hit && lk_msb;
        end
    end

`ifdef MIPS_BP_BTB_EN
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] up_tag;
    logic             vld [ENTRIES];
    logic [TAG_W-1:0] tag [ENTRIES];
    logic [PC_W-1:0]  tgt [ENTRIES];
    logic             hit_q;
    logic [PC_W-1:0]  tgt_q;

    assign lk_tag = lookup_pc[PC_W-1:IDX_W+2];
    assign up_tag = update_pc[PC_W-1:IDX_W+2];
    assign lk_hit = vld[lk_idx] && (tag[lk_idx] == lk_tag);
    assign up_hit = vld[up_idx] && (tag[up_idx] == up_tag);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                vld[i] <= 1'b0;
            end
        end else if (update_valid && update_taken) begin
            vld[up_idx] <= 1'b1;
        end
    end

    // Tag and target are only ever read qualified by vld, so no reset.
    always_ff @(posedge clock) begin
        if (update_valid && update_taken) begin
            tag[up_idx] <= up_tag;
            tgt[up_idx] <= update_target;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_q <= 1'b0;
            tgt_q <= '0;
        end else begin
            hit_q <= lookup_valid && lk_hit;
            tgt_q <= (lookup_valid && lk_hit) ? tgt[lk_idx] : '0;
        end
    end

    assign pred_hit    = hit_q;
    assign pred_target = tgt_q;
    assign unused      = ^{lookup_pc[1:0], update_pc[1:0]};
`else
    assign lk_hit      = 1'b1;
    assign up_hit      = 1'b1;
    assign pred_hit    = 1'b0;
    assign pred_target = '0;
    assign unused      = ^{lookup_pc[1:0], update_pc[1:0],
                           lookup_pc[PC_W-1:IDX_W+2],
                           update_pc[PC_W-1:IDX_W+2],
                           update_target};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (lookup_valid && (stat_lookups != 32'hFFFF_FFFF)) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (update_valid && (update_taken != update_pred_taken) &&
                (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Randomized scoreboard bench for mips_branch_predictor.
// Expected predictions come from a table model of the predictor rules.
module tb_mips_branch_predictor;
    localparam int ENTRIES = 64;
    localparam int CTR_W   = 2;
    localparam int PC_W    = 32;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int HALF    = 1 << (CTR_W - 1);

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            lookup_valid = 1'b0;
    logic [PC_W-1:0] lookup_pc = '0;
    logic            pred_valid;
    logic            pred_taken;
    logic            pred_hit;
    logic [PC_W-1:0] pred_target;
    logic            update_valid = 1'b0;
    logic [PC_W-1:0] update_pc = '0;
    logic            update_taken = 1'b0;
    logic [PC_W-1:0] update_target = '0;
    logic            update_pred_taken = 1'b0;
    logic [31:0]     stat_lookups;
    logic [31:0]     stat_mispredicts;

    always #5 clock = ~clock;

    mips_branch_predictor #(
        .ENTRIES(ENTRIES),
        .CTR_W  (CTR_W),
        .PC_W   (PC_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_hit         (pred_hit),
        .pred_target      (pred_target),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_taken     (update_taken),
        .update_target    (update_target),
        .update_pred_taken(update_pred_taken),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        int          stamp;
        logic        taken;
        logic        hit;
        logic [31:0] tgt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          m_ctr[ENTRIES];
    bit          m_vld[ENTRIES];
    logic [31:0] m_tag[ENTRIES];
    logic [31:0] m_tgt[ENTRIES];
    int unsigned m_lookups;
    int unsigned m_misp;
    logic [31:0] ra;
    logic [31:0] rb;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_vld[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_ctr[i] = HALF - 1;
            m_vld[i] = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        m_lookups = 0;
        m_misp    = 0;
    endtask

    function automatic exp_t predict(logic [31:0] pc);
        exp_t e;
        int   i;
        i = idx_of(pc);
        e.stamp = cyc;
`ifdef MIPS_BP_BTB_EN
        e.hit   = m_hit(pc);
        e.taken = e.hit && (m_ctr[i] >= HALF);
        e.tgt   = e.hit ? m_tgt[i] : 32'h0;
`else
        e.hit   = 1'b0;
        e.taken = (m_ctr[i] >= HALF);
        e.tgt   = 32'h0;
`endif
        return e;
    endfunction

    task automatic model_update(logic [31:0] pc, bit t, logic [31:0] tg);
        int i;
        bit h;
        i = idx_of(pc);
`ifdef MIPS_BP_BTB_EN
        h = m_hit(pc);
`else
        h = 1'b1;
`endif
        if (t && !h) begin
            m_ctr[i] = HALF;
        end else if (t) begin
            if (m_ctr[i] < CMAX) m_ctr[i]++;
        end else if (m_ctr[i] > 0) begin
            m_ctr[i]--;
        end
        if (t) begin
            m_vld[i] = 1'b1;
            m_tag[i] = tag_of(pc);
            m_tgt[i] = tg;
        end
    endtask

    task automatic drive(bit lv, logic [31:0] lpc, bit uv, logic [31:0] upc,
                         bit ut, logic [31:0] utg, bit upt);
        @(negedge clock);
        lookup_valid      = lv;
        lookup_pc         = lpc;
        update_valid      = uv;
        update_pc         = upc;
        update_taken      = ut;
        update_target     = utg;
        update_pred_taken = upt;
        if (lv) begin
            sb.push_back(predict(lpc));
            if (m_lookups != 32'hFFFF_FFFF) m_lookups++;
        end
        if (uv) begin
            model_update(upc, ut, utg);
            if ((ut != upt) && (m_misp != 32'hFFFF_FFFF)) m_misp++;
        end
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic chk_stats(string name);
        @(negedge clock);
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        chk({name, "_stat_lookups"}, stat_lookups, m_lookups);
        chk({name, "_stat_mispredicts"}, stat_mispredicts, m_misp);
    endtask

    task automatic soft_reset();
        @(negedge clock);
        #2;
        reset        = 1'b1;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        sb.delete();
        model_reset();
        @(negedge clock);
        #2 reset = 1'b0;
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] p;
        p = 32'h0040_0000;
        p = p | ($urandom_range(0, 3) << (IDX_W + 2));
        p = p | ($urandom_range(0, 7) << 2);
        p = p | $urandom_range(0, 3);
        return p;
    endfunction

    // Monitor: every presented prediction is matched against the queue head.
    always @(negedge clock) begin
        if (!reset) begin
            if (pred_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pred_unexpected: got pred_valid=1 required 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pred_latency", mon_e.stamp, cyc - 1);
                    chk("pred_taken", {31'b0, pred_taken}, {31'b0, mon_e.taken});
                    chk("pred_hit", {31'b0, pred_hit}, {31'b0, mon_e.hit});
                    chk("pred_target", pred_target, mon_e.tgt);
                end
            end else begin
                chk("idle_taken", {31'b0, pred_taken}, 32'h0);
                chk("idle_hit", {31'b0, pred_hit}, 32'h0);
                chk("idle_target", pred_target, 32'h0);
                checks++;
                if (sb.size() > 0 && sb[0].stamp < cyc) begin
                    failures++;
                    $display("FAIL pred_missing: got pred_valid=0 required 1 (cycle %0d)", cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("rst_pred_valid", {31'b0, pred_valid}, 32'h0);
        chk("rst_stat_lookups", stat_lookups, 32'h0);
        chk("rst_stat_mispredicts", stat_mispredicts, 32'h0);

        drive(1'b1, 32'h0040_0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk_stats("first_lookup");
        chk("first_lookup_count", stat_lookups, 32'd1);

        drive(1'b0, 32'h0, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
        drive(1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h0040_0110, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle();

        repeat (3) drive(1'b0, 32'h0, 1'b1, 32'h0040_0020, 1'b1, 32'h0040_0200, 1'b1);
        drive(1'b1, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (5) drive(1'b0, 32'h0, 1'b1, 32'h0040_0020, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle();

        drive(1'b1, 32'h0040_0030, 1'b1, 32'h0040_0033, 1'b1, 32'h0040_0400, 1'b0);
        drive(1'b1, 32'h0040_0030, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        idle();
        chk_stats("directed");

        soft_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h0040_0000 + 32'(k * 4), k[0], 32'h0040_1000, !k[0]);
        end
        chk_stats("misp10");
        chk("misp10_const", stat_mispredicts, 32'd10);

        drive(1'b1, 32'h0040_0044, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #2;
        reset        = 1'b1;
        lookup_valid = 1'b0;
        sb.delete();
        model_reset();
        #1;
        chk("async_pred_valid", {31'b0, pred_valid}, 32'h0);
        chk("async_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("async_pred_hit", {31'b0, pred_hit}, 32'h0);
        chk("async_pred_target", pred_target, 32'h0);
        chk("async_stat_lookups", stat_lookups, 32'h0);
        chk("async_stat_mispredicts", stat_mispredicts, 32'h0);
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("post_rst_pred_valid", {31'b0, pred_valid}, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            ra = rpc();
            rb = ($urandom_range(0, 3) == 0) ? ra : rpc();
            drive($urandom_range(0, 3) != 0, ra,
                  $urandom_range(0, 1) != 0, rb,
                  $urandom_range(0, 1) != 0, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 1) != 0);
            if (n % 500 == 499) chk_stats("rand");
            if (n == 1500) soft_reset();
        end
        repeat (3) idle();
        chk_stats("final");
        chk("sb_drained", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
